// File: rtl/cfg_bus_pkg.sv
// Shared types and defaults for the vending configuration bus.
// The configuration-bus initiator and its bench both import this package.
package cfg_bus_pkg;

    localparam int CFG_ADDR_W = 15;
    localparam int CFG_DATA_W = 32;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_e;

    typedef struct packed {
        logic                  write;
        logic [CFG_ADDR_W-1:0] addr;
        logic [CFG_DATA_W-1:0] wdata;
    } cmd_t;

    // The wait counter must hold values 0..timeout; it is never narrower than one bit.
    function automatic int wait_cnt_width(input int timeout);
        return (timeout < 1) ? 1 : $clog2(timeout + 1);
    endfunction

endpackage

// File: rtl/sat_counter.sv
// Up-counter that sticks at its all-ones value instead of wrapping.
module sat_counter #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             inc,
    output logic [WIDTH-1:0] count
);

    logic [WIDTH-1:0] count_q;
    logic [WIDTH-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (inc && (count_q != {WIDTH{1'b1}})) begin
            count_d = count_q + WIDTH'(1);
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;

endmodule

// File: rtl/apb_cfg_initiator.sv
// Single-outstanding APB-style bus master: one command in, one bus transfer, one response out.
// A transfer completes on any cycle with psel and pready both high; a wait-state timeout aborts it.
module apb_cfg_initiator
    import cfg_bus_pkg::*;
#(
    parameter int ADDR_W         = CFG_ADDR_W,
    parameter int DATA_W         = CFG_DATA_W,
    parameter int TIMEOUT_CYCLES = 64,
    parameter int CNT_W          = 8
) (
    input  logic              pclk,
    input  logic              prstn,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_write,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [DATA_W-1:0] cmd_wdata,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              rsp_err,
    output logic [ADDR_W-1:0] paddr,
    output logic              psel,
    output logic              pwrite,
    output logic [DATA_W-1:0] pwdata,
    input  logic [DATA_W-1:0] prdata,
    input  logic              pready,
    output logic [CNT_W-1:0]  xfer_count,
    output logic [CNT_W-1:0]  err_count
);

    localparam int                WAIT_W     = wait_cnt_width(TIMEOUT_CYCLES);
    localparam bit                TIMEOUT_EN = (TIMEOUT_CYCLES != 0);
    localparam logic [WAIT_W-1:0] WAIT_LAST  = WAIT_W'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);

    state_e            state_q,     state_d;
    logic              cmd_ready_q, cmd_ready_d;
    logic              psel_q,      psel_d;
    logic              pwrite_q,    pwrite_d;
    logic [ADDR_W-1:0] paddr_q,     paddr_d;
    logic [DATA_W-1:0] pwdata_q,    pwdata_d;
    logic              rsp_valid_q, rsp_valid_d;
    logic              rsp_err_q,   rsp_err_d;
    logic [DATA_W-1:0] rsp_rdata_q, rsp_rdata_d;
    logic [WAIT_W-1:0] wait_cnt_q,  wait_cnt_d;

    logic accept;
    logic done;
    logic abort;

    assign accept = (state_q == IDLE) && cmd_valid && cmd_ready_q;
    assign done   = (state_q == ACCESS) && pready;
    // pready wins over the timeout, so a response on the last allowed cycle is not an error.
    assign abort  = (state_q == ACCESS) && !pready && TIMEOUT_EN && (wait_cnt_q == WAIT_LAST);

    // Register process: FSM state plus every registered output.
    always_ff @(posedge pclk or negedge prstn) begin
        if (!prstn) begin
            state_q     <= IDLE;
            cmd_ready_q <= 1'b1;
            psel_q      <= 1'b0;
            pwrite_q    <= 1'b0;
            paddr_q     <= '0;
            pwdata_q    <= '0;
            rsp_valid_q <= 1'b0;
            rsp_err_q   <= 1'b0;
            rsp_rdata_q <= '0;
            wait_cnt_q  <= '0;
        end else begin
            state_q     <= state_d;
            cmd_ready_q <= cmd_ready_d;
            psel_q      <= psel_d;
            pwrite_q    <= pwrite_d;
            paddr_q     <= paddr_d;
            pwdata_q    <= pwdata_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_err_q   <= rsp_err_d;
            rsp_rdata_q <= rsp_rdata_d;
            wait_cnt_q  <= wait_cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (accept)        state_d = ACCESS;
            ACCESS:  if (done || abort) state_d = RESP;
            RESP:    if (rsp_ready)     state_d = IDLE;
            default:                    state_d = IDLE;
        endcase
    end

    // NOTE: every _d gets a hold-value default first, so no path through the case infers a latch.
    always_comb begin
        cmd_ready_d = cmd_ready_q;
        psel_d      = psel_q;
        pwrite_d    = pwrite_q;
        paddr_d     = paddr_q;
        pwdata_d    = pwdata_q;
        rsp_valid_d = rsp_valid_q;
        rsp_err_d   = rsp_err_q;
        rsp_rdata_d = rsp_rdata_q;
        wait_cnt_d  = wait_cnt_q;

        unique case (state_q)
            IDLE: begin
                if (accept) begin
                    cmd_ready_d = 1'b0;
                    psel_d      = 1'b1;
                    pwrite_d    = cmd_write;
                    paddr_d     = cmd_addr;
                    pwdata_d    = cmd_write ? cmd_wdata : '0;
                    wait_cnt_d  = '0;
                end
            end
            ACCESS: begin
                if (done || abort) begin
                    psel_d      = 1'b0;
                    pwrite_d    = 1'b0;
                    paddr_d     = '0;
                    pwdata_d    = '0;
                    rsp_valid_d = 1'b1;
                    rsp_err_d   = abort;
                    rsp_rdata_d = (done && !pwrite_q) ? prdata : '0;
                end else begin
                    wait_cnt_d  = wait_cnt_q + WAIT_W'(1);
                end
            end
            RESP: begin
                // rsp_rdata/rsp_err stay put after the handshake until the next response.
                if (rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    cmd_ready_d = 1'b1;
                end
            end
            default: begin
                cmd_ready_d = 1'b1;
                psel_d      = 1'b0;
                rsp_valid_d = 1'b0;
            end
        endcase
    end

    sat_counter #(.WIDTH(CNT_W)) u_xfer_count (
        .clk   (pclk),
        .rst_n (prstn),
        .inc   (done || abort),
        .count (xfer_count)
    );

    sat_counter #(.WIDTH(CNT_W)) u_err_count (
        .clk   (pclk),
        .rst_n (prstn),
        .inc   (abort),
        .count (err_count)
    );

    assign cmd_ready = cmd_ready_q;
    assign psel      = psel_q;
    assign pwrite    = pwrite_q;
    assign paddr     = paddr_q;
    assign pwdata    = pwdata_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_err   = rsp_err_q;
    assign rsp_rdata = rsp_rdata_q;

endmodule

// File: tb/tb_apb_cfg_initiator.sv
// Bench for apb_cfg_initiator with a four-cycle timeout; a transaction-level model predicts each
// transfer's psel duration, response and counters from its wait-state count.
module tb_apb_cfg_initiator;
    import cfg_bus_pkg::*;

    localparam int ADDR_W  = CFG_ADDR_W;
    localparam int DATA_W  = CFG_DATA_W;
    localparam int TO      = 4;
    localparam int CNT_W   = 8;
    localparam int CNT_MAX = (1 << CNT_W) - 1;
    localparam int STUCK   = 1000;

    logic              pclk = 1'b0;
    logic              prstn;
    logic              cmd_valid, cmd_ready, cmd_write;
    logic [ADDR_W-1:0] cmd_addr;
    logic [DATA_W-1:0] cmd_wdata;
    logic              rsp_valid, rsp_ready, rsp_err;
    logic [DATA_W-1:0] rsp_rdata;
    logic [ADDR_W-1:0] paddr;
    logic              psel, pwrite, pready;
    logic [DATA_W-1:0] pwdata, prdata;
    logic [CNT_W-1:0]  xfer_count, err_count;

    apb_cfg_initiator #(
        .ADDR_W(ADDR_W), .DATA_W(DATA_W), .TIMEOUT_CYCLES(TO), .CNT_W(CNT_W)
    ) dut (
        .pclk(pclk), .prstn(prstn),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
        .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
        .paddr(paddr), .psel(psel), .pwrite(pwrite), .pwdata(pwdata),
        .prdata(prdata), .pready(pready),
        .xfer_count(xfer_count), .err_count(err_count)
    );

    always #5 pclk = ~pclk;

    int   n_vec = 0;
    int   n_err = 0;
    int   exp_xfer = 0;
    int   exp_errs = 0;
    logic pend_valid = 1'b0;
    cmd_t pend;

    // Transaction-level expectation: a responder that waits `waits` cycles either answers
    // inside the timeout window or the transfer is cut off after TO select cycles.
    function automatic void predict(input cmd_t c, input int waits, input logic [DATA_W-1:0] prd,
                                    output int cyc, output logic err, output logic [DATA_W-1:0] rd);
        err = (waits >= TO);
        cyc = err ? TO : waits + 1;
        rd  = (err || c.write) ? '0 : prd;
    endfunction

    function automatic cmd_t rand_cmd();
        cmd_t c;
        c.write = 1'($urandom_range(0, 1));
        c.addr  = ADDR_W'($urandom());
        c.wdata = $urandom();
        return c;
    endfunction

    // Starts and ends on a falling edge with the DUT idle.
    task automatic run_xfer(input cmd_t c, input int waits, input logic [DATA_W-1:0] prd,
                            input int hold, input string tag);
        int                k;
        int                exp_cyc;
        logic              exp_e;
        logic [DATA_W-1:0] exp_rd;
        logic [DATA_W-1:0] exp_pw;
        cmd_t              junk;

        predict(c, waits, prd, exp_cyc, exp_e, exp_rd);
        exp_pw    = c.write ? c.wdata : '0;
        cmd_valid = 1'b1;
        cmd_write = c.write;
        cmd_addr  = c.addr;
        cmd_wdata = c.wdata;
        n_vec++;
        if ({cmd_ready, psel} !== 2'b10) begin
            n_err++;
            $display("FAIL %s idle: cmd_ready,psel=%b required 10", tag, {cmd_ready, psel});
        end
        @(posedge pclk);
        #1;
        junk      = rand_cmd();
        cmd_valid = 1'b0;
        cmd_write = junk.write;
        cmd_addr  = junk.addr;
        cmd_wdata = junk.wdata;

        k = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge pclk);
            if (psel !== 1'b1) break;
            k++;
            n_vec++;
            if ({paddr, pwrite, pwdata, cmd_ready, rsp_valid} !== {c.addr, c.write, exp_pw, 2'b00}) begin
                n_err++;
                $display("FAIL %s bus cycle %0d: addr=%h wr=%b wdata=%h rdy=%b rv=%b required addr=%h wr=%b wdata=%h rdy=0 rv=0",
                         tag, k, paddr, pwrite, pwdata, cmd_ready, rsp_valid, c.addr, c.write, exp_pw);
            end
            pready = (k == waits + 1);
            prdata = pready ? prd : $urandom();
        end
        pready = 1'($urandom_range(0, 1));
        prdata = $urandom();

        n_vec++;
        if (k !== exp_cyc) begin
            n_err++;
            $display("FAIL %s psel_cycles: got %0d required %0d", tag, k, exp_cyc);
        end
        exp_xfer = (exp_xfer < CNT_MAX) ? exp_xfer + 1 : CNT_MAX;
        if (exp_e) exp_errs = (exp_errs < CNT_MAX) ? exp_errs + 1 : CNT_MAX;
        n_vec++;
        if ({rsp_valid, rsp_err, rsp_rdata} !== {1'b1, exp_e, exp_rd}) begin
            n_err++;
            $display("FAIL %s response: valid=%b err=%b rdata=%h required 1 %b %h",
                     tag, rsp_valid, rsp_err, rsp_rdata, exp_e, exp_rd);
        end
        n_vec++;
        if ({xfer_count, err_count} !== {CNT_W'(exp_xfer), CNT_W'(exp_errs)}) begin
            n_err++;
            $display("FAIL %s counters: xfer=%0d err=%0d required %0d %0d",
                     tag, xfer_count, err_count, exp_xfer, exp_errs);
        end

        rsp_ready = 1'b0;
        if (pend_valid) begin
            cmd_valid = 1'b1;
            cmd_write = pend.write;
            cmd_addr  = pend.addr;
            cmd_wdata = pend.wdata;
        end
        for (int h = 0; h < hold; h++) begin
            @(negedge pclk);
            n_vec++;
            if ({rsp_valid, rsp_err, rsp_rdata, psel, cmd_ready} !== {1'b1, exp_e, exp_rd, 2'b00}) begin
                n_err++;
                $display("FAIL %s hold %0d: valid=%b err=%b rdata=%h psel=%b rdy=%b required 1 %b %h 0 0",
                         tag, h, rsp_valid, rsp_err, rsp_rdata, psel, cmd_ready, exp_e, exp_rd);
            end
        end
        rsp_ready = 1'b1;
        @(posedge pclk);
        #1 rsp_ready = 1'b0;
        @(negedge pclk);
        n_vec++;
        if ({rsp_valid, cmd_ready, psel, rsp_err, rsp_rdata} !== {3'b010, exp_e, exp_rd}) begin
            n_err++;
            $display("FAIL %s after handshake: valid=%b rdy=%b psel=%b err=%b rdata=%h required 0 1 0 %b %h",
                     tag, rsp_valid, cmd_ready, psel, rsp_err, rsp_rdata, exp_e, exp_rd);
        end
    endtask

    task automatic test_reset();
        cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0; cmd_wdata = '0;
        rsp_ready = 1'b0; pready = 1'b0; prdata = '0;
        prstn = 1'b1;
        #1 prstn = 1'b0;
        #2;
        n_vec++;
        if ({cmd_ready, psel, pwrite, paddr, pwdata, rsp_valid, rsp_rdata, rsp_err, xfer_count, err_count}
            !== {3'b100, {ADDR_W{1'b0}}, {DATA_W{1'b0}}, 1'b0, {DATA_W{1'b0}}, 1'b0, {2*CNT_W{1'b0}}}) begin
            n_err++;
            $display("FAIL reset values: rdy=%b psel=%b pwrite=%b paddr=%h pwdata=%h rv=%b rdata=%h err=%b cnt=%0d/%0d required 1 0 0 0 0 0 0 0 0/0",
                     cmd_ready, psel, pwrite, paddr, pwdata, rsp_valid, rsp_rdata, rsp_err, xfer_count, err_count);
        end
        cmd_valid = 1'b1; pready = 1'b1; rsp_ready = 1'b1;
        repeat (2) @(negedge pclk);
        n_vec++;
        if ({cmd_ready, psel, rsp_valid} !== 3'b100) begin
            n_err++;
            $display("FAIL reset held: rdy,psel,rv=%b required 100", {cmd_ready, psel, rsp_valid});
        end
        cmd_valid = 1'b0; pready = 1'b0; rsp_ready = 1'b0;
        prstn = 1'b1;
        @(negedge pclk);
    endtask

    task automatic test_write_zero_wait();
        run_xfer('{1'b1, 15'h0005, 32'hDEADBEEF}, 0, 32'h0, 0, "write_zero_wait");
    endtask

    task automatic test_read_wait3();
        run_xfer('{1'b0, 15'h0012, 32'h5555AAAA}, 3, 32'h00640003, 1, "read_wait3");
    endtask

    task automatic test_timeout();
        run_xfer('{1'b0, 15'h0033, 32'h0}, STUCK, 32'hFFFFFFFF, 0, "timeout_read");
        run_xfer('{1'b1, 15'h7FFF, 32'h12345678}, STUCK, 32'h0, 2, "timeout_write");
    endtask

    task automatic test_boundary();
        run_xfer('{1'b1, 15'h0100, 32'hCAFEF00D}, TO - 1, 32'h0, 0, "boundary_write");
        run_xfer('{1'b0, 15'h0101, 32'h0}, TO - 1, 32'hA5A5A5A5, 0, "boundary_read");
    endtask

    task automatic test_backpressure();
        cmd_t first;
        first      = '{1'b1, 15'h0040, 32'h11112222};
        pend       = '{1'b0, 15'h0041, 32'h33334444};
        pend_valid = 1'b1;
        run_xfer(first, 1, 32'h0, 10, "backpressure_first");
        pend_valid = 1'b0;
        run_xfer(pend, 0, 32'h0BADCAFE, 0, "backpressure_second");
    endtask

    task automatic test_random(input int n, input string tag);
        for (int i = 0; i < n; i++) begin
            run_xfer(rand_cmd(), $urandom_range(0, TO + 2), $urandom(), $urandom_range(0, 3), tag);
        end
    endtask

    task automatic test_reset_mid();
        cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 15'h0777; cmd_wdata = 32'h87654321;
        pready    = 1'b0;
        @(posedge pclk);
        #1 cmd_valid = 1'b0;
        @(negedge pclk);
        n_vec++;
        if (psel !== 1'b1) begin
            n_err++;
            $display("FAIL reset_mid setup: psel=%b required 1", psel);
        end
        #2 prstn = 1'b0;
        #1;
        n_vec++;
        if ({psel, rsp_valid, cmd_ready, xfer_count, err_count} !== {3'b001, {2*CNT_W{1'b0}}}) begin
            n_err++;
            $display("FAIL reset_mid async: psel=%b rv=%b rdy=%b cnt=%0d/%0d required 0 0 1 0/0",
                     psel, rsp_valid, cmd_ready, xfer_count, err_count);
        end
        exp_xfer = 0;
        exp_errs = 0;
        @(negedge pclk);
        prstn = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge pclk);
            n_vec++;
            if ({psel, rsp_valid, cmd_ready, xfer_count, err_count} !== {3'b001, {2*CNT_W{1'b0}}}) begin
                n_err++;
                $display("FAIL reset_mid after %0d: psel=%b rv=%b rdy=%b cnt=%0d/%0d required 0 0 1 0/0",
                         i, psel, rsp_valid, cmd_ready, xfer_count, err_count);
            end
        end
    endtask

    task automatic test_saturation();
        test_random(300, "saturation");
        n_vec++;
        if (xfer_count !== CNT_W'(CNT_MAX)) begin
            n_err++;
            $display("FAIL saturation final: xfer_count=%0d required %0d", xfer_count, CNT_MAX);
        end
    endtask

    initial begin
        test_reset();
        test_write_zero_wait();
        test_read_wait3();
        test_timeout();
        test_boundary();
        test_backpressure();
        test_random(40, "random");
        test_reset_mid();
        test_saturation();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
